tia_clock_divider: RTL

- Parametrised successor to the fixed TIA divide-by-three phase generator.
- Divides the master colour clock by a build-time divisor, or by an alternate divisor selected at run time.
- Produces registered, glitch-free outputs: phi_theta, non-overlapping two-phase phi1/phi2, and an end-of-period tick.
- Sits between the oscillator input and the CPU-clock and horizontal-timing logic.
- Supports synchronous phase realignment (resphi0) independent of the global asynchronous reset.

---
 rtl/tia_pkg.sv | 26 ++
 rtl/tia_clock_divider_if.sv | 32 +++
 rtl/tia_phase_decode.sv | 23 ++
 rtl/tia_clock_divider.sv | 87 ++++++++
 4 files changed

// File: rtl/tia_pkg.sv
// Shared TIA timing definitions: divisor limits, phase index type and the
// half-period helper used by every phase decoder in the TIA timing chain.
package tia_pkg;

  localparam int unsigned TIA_DIV_MIN = 3;

  // Widest phase index any TIA timing block decodes.
  localparam int unsigned TIA_PHASE_W = 8;

  typedef logic [TIA_PHASE_W-1:0] tia_phase_t;
  typedef int unsigned            tia_div_t;

  typedef enum logic {
    DIV_PRI = 1'b0,
    DIV_ALT = 1'b1
  } div_sel_e;

  function automatic tia_div_t divisor_half(input tia_div_t d);
    return d >> 1;
  endfunction

  function automatic tia_div_t div_max(input tia_div_t a, input tia_div_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tia_clock_divider_if.sv
// Control and phase-output bundle of the TIA clock divider.
// The halt signal exists only when TIA_CLOCK_DIVIDER_HALT_EN is defined.
interface tia_clock_divider_if #(
    parameter int unsigned CNT_W = 2
);
  logic             resphi0;
  logic             div_sel;
`ifdef TIA_CLOCK_DIVIDER_HALT_EN
  logic             halt;
`endif
  logic             phi_theta;
  logic             phi1;
  logic             phi2;
  logic             tick;
  logic [CNT_W-1:0] phase;

  modport master (
      output resphi0, div_sel,
`ifdef TIA_CLOCK_DIVIDER_HALT_EN
      output halt,
`endif
      input  phi_theta, phi1, phi2, tick, phase
  );

  modport slave (
      input  resphi0, div_sel,
`ifdef TIA_CLOCK_DIVIDER_HALT_EN
      input  halt,
`endif
      output phi_theta, phi1, phi2, tick, phase
  );
endinterface

// File: rtl/tia_phase_decode.sv
// Combinational phase decode: phase index and divisor to phi_theta, the
// non-overlapping phi1/phi2 pair (phase D/2 is dead) and the last-phase tick.
module tia_phase_decode
  import tia_pkg::*;
(
    input  tia_phase_t cnt,
    input  tia_div_t   d,
    output logic       phi_theta,
    output logic       phi1,
    output logic       phi2,
    output logic       tick
);
  tia_div_t c;
  tia_div_t h;

  assign c = tia_div_t'(cnt);
  assign h = divisor_half(d);

  assign phi_theta = (c == 0);
  assign phi1      = (c < h);
  assign phi2      = (c > h) && (c <= d - 1);
  assign tick      = (c == d - 1);
endmodule

// File: rtl/tia_clock_divider.sv
// Parametrised TIA phase generator with registered, glitch-free outputs.
// Optional halt input when built with TIA_CLOCK_DIVIDER_HALT_EN defined.
module tia_clock_divider
  import tia_pkg::*;
#(
    parameter int unsigned DIVISOR     = 3,
    parameter int unsigned ALT_DIVISOR = 4,
    parameter int unsigned CNT_W       = $clog2(div_max(DIVISOR, ALT_DIVISOR))
) (
    input logic                clk,
    input logic                reset,
    tia_clock_divider_if.slave bus
);
  div_sel_e         sel_q, sel_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  tia_div_t         d_cur, d_n;
  logic             halted;
  logic             dec_theta, dec_phi1, dec_phi2, dec_tick;
  logic             phi_theta_q, phi1_q, phi2_q, tick_q;

  function automatic tia_div_t div_of(input div_sel_e s);
    return (s == DIV_ALT) ? ALT_DIVISOR : DIVISOR;
  endfunction

  assign d_cur = div_of(sel_q);
  assign d_n   = div_of(sel_n);

  // NOTE: every variable gets a default before the if-chain so no branch
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_n  = cnt_q;
    sel_n  = sel_q;
    halted = 1'b0;
    if (bus.resphi0) begin
      cnt_n = '0;
      sel_n = div_sel_e'(bus.div_sel);
    end
`ifdef TIA_CLOCK_DIVIDER_HALT_EN
    else if (bus.halt) begin
      halted = 1'b1;
    end
`endif
    // >= also pulls an out-of-range count back to phase 0.
    else if (tia_div_t'(cnt_q) >= d_cur - 1) begin
      cnt_n = '0;
      sel_n = div_sel_e'(bus.div_sel);
    end else begin
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  // Decode the next state so the registered outputs line up with cnt_q.
  tia_phase_decode u_decode (
      .cnt      (tia_phase_t'(cnt_n)),
      .d        (d_n),
      .phi_theta(dec_theta),
      .phi1     (dec_phi1),
      .phi2     (dec_phi2),
      .tick     (dec_tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      sel_q       <= DIV_PRI;
      phi_theta_q <= 1'b1;
      phi1_q      <= 1'b1;
      phi2_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_n;
      sel_q       <= sel_n;
      phi_theta_q <= dec_theta;
      phi1_q      <= dec_phi1;
      phi2_q      <= dec_phi2;
      tick_q      <= dec_tick & ~halted;
    end
  end

  assign bus.phi_theta = phi_theta_q;
  assign bus.phi1      = phi1_q;
  assign bus.phi2      = phi2_q;
  assign bus.tick      = tick_q;
  assign bus.phase     = cnt_q;
endmodule
